// File: rtl/sevseg_scan_mux.sv
// sevseg_scan_mux: time-multiplexes per-digit seven-segment patterns onto a shared bus with one-hot digit enables.
// Optional blinking of masked digits is built only when SEVSEG_BLINK_EN is defined.
module sevseg_scan_mux #(
    parameter int NUM_DIGITS     = 8,
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int DIG_ACTIVE_LOW = 0,
    parameter int BLINK_FRAMES   = 250
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_DIGITS*7-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LD = BLANK_CYCLES > 0 ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n, idx_adv;
    logic [CW-1:0]   cnt, cnt_n;
    logic [6:0]      seg_q, seg_q_n;
    logic            last, wrap, blank_seg;

    assign last    = idx == IW'(NUM_DIGITS - 1);
    assign idx_adv = last ? '0 : idx + IW'(1);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        seg_q_n = seg_q;
        wrap    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = LOAD;
                    idx_n   = '0;
                end
                LOAD: begin
                    seg_q_n = seg_in[idx*7 +: 7];
                    state_n = SHOW;
                    cnt_n   = DWELL_LD;
                end
                SHOW: begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == '0) begin
                        if (BLANK_CYCLES == 0) begin
                            state_n = LOAD;
                            idx_n   = idx_adv;
                            wrap    = last;
                            cnt_n   = '0;
                        end else begin
                            state_n = BLANK;
                            cnt_n   = BLANK_LD;
                        end
                    end
                end
                default: begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == '0) begin
                        state_n = LOAD;
                        idx_n   = idx_adv;
                        wrap    = last;
                        cnt_n   = '0;
                    end
                end
            endcase
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] fcnt;
    logic          phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (!enable) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign blank_seg = phase && blink_mask[idx_n];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blank_seg = 1'b0;
`endif

    // Outputs are registered from next-state values so they are valid in the cycle a state is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            seg_q      <= 7'h7F;
            seg_out    <= 7'h7F;
            dig_en     <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            seg_q      <= seg_q_n;
            seg_out    <= (state_n == SHOW && !blank_seg) ? seg_q_n : 7'h7F;
            dig_en     <= state_n == SHOW ? DIG_OFF ^ (NUM_DIGITS'(1) << idx_n) : DIG_OFF;
            frame_tick <= wrap;
        end
    end
endmodule

// File: tb/tb_sevseg_scan_mux.sv
// tb_sevseg_scan_mux: directed checks of scan order, slot timing, sampling, enable drop and async reset.
// A second instance covers the no-blanking-gap configuration.
module tb_sevseg_scan_mux;
    logic        clk = 1'b0;
    logic        reset_n, rst2, enable, en2;
    logic [27:0] seg_in;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_out, seg2;
    logic [3:0]  dig_en, dig2;
    logic        frame_tick, tick2;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [6:0]  segs [4];

    always #5 clk = ~clk;

    sevseg_scan_mux #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .DIG_ACTIVE_LOW(0)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .seg_in(seg_in), .blink_mask(blink_mask),
        .seg_out(seg_out), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    sevseg_scan_mux #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0), .DIG_ACTIVE_LOW(0)) dut2 (
        .clk(clk), .reset_n(rst2), .enable(en2), .seg_in(seg_in), .blink_mask(blink_mask),
        .seg_out(seg2), .dig_en(dig2), .frame_tick(tick2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] s, input logic [3:0] d, input logic t);
        check({tag, ".seg"}, 32'(seg_out), 32'(s));
        check({tag, ".dig"}, 32'(dig_en), 32'(d));
        check({tag, ".tick"}, 32'(frame_tick), 32'(t));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [6:0] s, input logic [3:0] d, input logic t, input logic mod);
        step();
        chk_out("load", 7'h7F, 4'b0000, t);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("show", s, d, 1'b0);
            if (mod && i == 1) seg_in[6:0] = 7'h12;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out("blank", 7'h7F, 4'b0000, 1'b0);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        rst2       = 1'b0;
        enable     = 1'b1;
        en2        = 1'b0;
        seg_in     = {7'h40, 7'h79, 7'h24, 7'h30};
        blink_mask = 4'b0010;
        repeat (3) begin
            step();
            chk_out("reset", 7'h7F, 4'b0000, 1'b0);
        end
        reset_n = 1'b1;
        slot(7'h30, 4'b0001, 1'b0, 1'b0);
        slot(7'h24, 4'b0010, 1'b0, 1'b0);
        slot(7'h79, 4'b0100, 1'b0, 1'b0);
        slot(7'h40, 4'b1000, 1'b0, 1'b0);
        slot(7'h30, 4'b0001, 1'b1, 1'b1);
        slot(7'h24, 4'b0010, 1'b0, 1'b0);
        slot(7'h79, 4'b0100, 1'b0, 1'b0);
        slot(7'h40, 4'b1000, 1'b0, 1'b0);
        slot(7'h12, 4'b0001, 1'b1, 1'b0);
        slot(7'h24, 4'b0010, 1'b0, 1'b0);
        step();
        chk_out("d2load", 7'h7F, 4'b0000, 1'b0);
        step();
        chk_out("d2show", 7'h79, 4'b0100, 1'b0);
        step();
        chk_out("d2show", 7'h79, 4'b0100, 1'b0);
        enable = 1'b0;
        step();
        chk_out("drop", 7'h7F, 4'b0000, 1'b0);
        step();
        chk_out("idle", 7'h7F, 4'b0000, 1'b0);
        enable = 1'b1;
        step();
        chk_out("reload", 7'h7F, 4'b0000, 1'b0);
        step();
        chk_out("restart", 7'h12, 4'b0001, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 7'h7F, 4'b0000, 1'b0);
        step();
        chk_out("held_rst", 7'h7F, 4'b0000, 1'b0);

        segs[0] = 7'h12;
        segs[1] = 7'h24;
        segs[2] = 7'h79;
        segs[3] = 7'h40;
        rst2 = 1'b1;
        en2  = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            int p, d;
            step();
            p = (c - 1) % 5;
            d = ((c - 1) / 5) % 4;
            check("nb.tick", 32'(tick2), 32'(c == 21 || c == 41));
            check("nb.dig", 32'(dig2), p == 0 ? 32'd0 : 32'd1 << d);
            check("nb.seg", 32'(seg2), p == 0 ? 32'h7F : 32'(segs[d]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
